// File: rtl/reg_file_mp.sv
// Multi-port register file with same-cycle write-to-read bypass and a
// hardware clear sweep that zeroes the array after reset or on request.
module reg_file_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 4,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clr_req,
  output logic                     ready,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                ready_q, ready_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];

  logic [ADDR_W-1:0]   wr_addr [NUM_WR];
  logic [DATA_W-1:0]   wr_data [NUM_WR];
  logic [ADDR_W-1:0]   rd_addr [NUM_RD];
  logic [NUM_WR-1:0]   wr_ok;

  // Unpack the flat port buses into per-port views.
  always_comb begin
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      wr_addr[k] = waddr[k*ADDR_W +: ADDR_W];
      wr_data[k] = wdata[k*DATA_W +: DATA_W];
    end
    for (int unsigned j = 0; j < NUM_RD; j++) begin
      rd_addr[j] = raddr[j*ADDR_W +: ADDR_W];
    end
  end

  // State register and sweep counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Next-state: sweep once through the array, then serve until a clear request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
    ready_d = (state_d == ST_READY);
  end

  assign ready = ready_q;

  // A write port is live only when serving and not targeting a hardwired r0.
  always_comb begin
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      wr_ok[k] = we[k] && (state_q == ST_READY) &&
                 !((ZERO_REG != 0) && (wr_addr[k] == '0));
    end
  end

  // Array update; ascending port order lets the higher index win a collision.
  always_comb begin
    mem_d = mem_q;
    if (state_q == ST_CLEAR) begin
      mem_d[cnt_q] = '0;
    end else begin
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (wr_ok[k]) begin
          mem_d[wr_addr[k]] = wr_data[k];
        end
      end
    end
  end

  // Storage is not reset; the sweep defines every entry before first use.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Combinational read with r0 and enable masking taking priority over bypass.
  always_comb begin
    rdata = '0;
    for (int unsigned j = 0; j < NUM_RD; j++) begin
      if ((state_q == ST_READY) && re[j] &&
          !((ZERO_REG != 0) && (rd_addr[j] == '0))) begin
        rdata[j*DATA_W +: DATA_W] = mem_q[rd_addr[j]];
        if (BYPASS != 0) begin
          for (int unsigned k = 0; k < NUM_WR; k++) begin
            if (wr_ok[k] && (wr_addr[k] == rd_addr[j])) begin
              rdata[j*DATA_W +: DATA_W] = wr_data[k];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: directed vector table, hand-written clear/reset
// sequences, and randomized traffic against an array-based reference model.
module tb_reg_file_mp;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NUM_RD = 4;
  localparam int unsigned NUM_WR = 2;
  localparam int unsigned DEPTH  = 32;

  logic                     clk = 1'b0;
  logic                     rstn;
  logic                     clr_req;
  logic                     ready;
  logic [NUM_WR-1:0]        we;
  logic [NUM_WR*ADDR_W-1:0] waddr;
  logic [NUM_WR*DATA_W-1:0] wdata;
  logic [NUM_RD-1:0]        re;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;

  always #5 clk = ~clk;

  reg_file_mp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
    .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk), .rstn(rstn), .clr_req(clr_req), .ready(ready),
    .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference: plain array of register values plus cycles left until usable.
  logic [31:0] mdl_mem [DEPTH];
  int          clear_left;

  typedef struct packed {
    logic [1:0]   we;
    logic [9:0]   waddr;
    logic [63:0]  wdata;
    logic [3:0]   re;
    logic [19:0]  raddr;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void mdl_clear();
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
  endfunction

  function automatic logic [31:0] mdl_read(input int j);
    logic [4:0]  a;
    logic [31:0] v;
    a = raddr[j*ADDR_W +: ADDR_W];
    if (!rstn || clear_left != 0 || !re[j] || a == 5'd0) return '0;
    v = mdl_mem[a];
    for (int k = 0; k < NUM_WR; k++) begin
      if (we[k] && waddr[k*ADDR_W +: ADDR_W] == a) v = wdata[k*DATA_W +: DATA_W];
    end
    return v;
  endfunction

  // Check outputs on the falling edge, then advance one rising edge.
  task automatic step(input bit has_exp, input logic [127:0] exp);
    @(negedge clk);
    check("ready", 32'(ready), 32'(rstn && clear_left == 0));
    for (int j = 0; j < NUM_RD; j++) begin
      check($sformatf("model_rdata%0d", j), rdata[j*DATA_W +: DATA_W], mdl_read(j));
      if (has_exp)
        check($sformatf("table_rdata%0d", j), rdata[j*DATA_W +: DATA_W], exp[j*32 +: 32]);
    end
    @(posedge clk);
    if (!rstn) begin
      clear_left = DEPTH;
      mdl_clear();
    end else if (clear_left != 0) begin
      clear_left--;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (we[k] && waddr[k*ADDR_W +: ADDR_W] != 5'd0)
          mdl_mem[waddr[k*ADDR_W +: ADDR_W]] = wdata[k*DATA_W +: DATA_W];
      end
      if (clr_req) begin
        clear_left = DEPTH;
        mdl_clear();
      end
    end
    #1;
  endtask

  task automatic read_all_zero();
    we = '0;
    re = 4'hF;
    for (int i = 0; i < 8; i++) begin
      raddr = {5'(4*i+3), 5'(4*i+2), 5'(4*i+1), 5'(4*i)};
      step(1'b1, 128'd0);
    end
  endtask

  // Count rising edges until ready, with optional write noise and a second clear pulse.
  task automatic count_sweep(input string name, input bit noise);
    int n;
    n = 0;
    while (!ready && n < 100) begin
      if (noise) begin
        we    = 2'b11;
        waddr = 10'($urandom);
        wdata = {$urandom, $urandom};
        clr_req = (n == 5);
      end
      re    = 4'($urandom);
      raddr = 20'($urandom);
      step(1'b0, '0);
      n++;
    end
    clr_req = 1'b0;
    we      = '0;
    check(name, 32'(n), 32'd32);
  endtask

  function automatic vec_t mk(input logic [1:0] w, input int wa0, input int wa1,
                              input logic [31:0] wd0, input logic [31:0] wd1,
                              input logic [3:0] r, input int ra0, input int ra1,
                              input int ra2, input int ra3,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3);
    vec_t v;
    v.we    = w;
    v.waddr = {5'(wa1), 5'(wa0)};
    v.wdata = {wd1, wd0};
    v.re    = r;
    v.raddr = {5'(ra3), 5'(ra2), 5'(ra1), 5'(ra0)};
    v.exp   = {e3, e2, e1, e0};
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    vecs[0]  = mk(2'b01, 3, 0, 32'hDEADBEEF, 0, 4'b1111, 3, 3, 5, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    vecs[1]  = mk(2'b00, 0, 0, 0, 0, 4'b0011, 3, 3, 3, 3, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    vecs[2]  = mk(2'b11, 7, 7, 32'h11111111, 32'h22222222, 4'b1111, 7, 7, 3, 8,
                  32'h22222222, 32'h22222222, 32'hDEADBEEF, 0);
    vecs[3]  = mk(2'b00, 0, 0, 0, 0, 4'b1111, 7, 3, 7, 0, 32'h22222222, 32'hDEADBEEF, 32'h22222222, 0);
    vecs[4]  = mk(2'b01, 0, 0, 32'hFFFFFFFF, 0, 4'b1111, 0, 0, 3, 7, 0, 0, 32'hDEADBEEF, 32'h22222222);
    vecs[5]  = mk(2'b11, 9, 0, 32'h12345678, 32'hFFFFFFFF, 4'b1011, 0, 9, 9, 7, 0, 32'h12345678, 0, 32'h22222222);
    vecs[6]  = mk(2'b00, 0, 0, 0, 0, 4'b1111, 0, 9, 7, 3, 0, 32'h12345678, 32'h22222222, 32'hDEADBEEF);
    vecs[7]  = mk(2'b00, 0, 0, 0, 0, 4'b0000, 9, 7, 3, 1, 0, 0, 0, 0);
    vecs[8]  = mk(2'b11, 10, 11, 32'hAAAA5555, 32'h5555AAAA, 4'b1111, 10, 11, 10, 11,
                  32'hAAAA5555, 32'h5555AAAA, 32'hAAAA5555, 32'h5555AAAA);
    vecs[9]  = mk(2'b00, 0, 0, 0, 0, 4'b1111, 10, 11, 9, 0, 32'hAAAA5555, 32'h5555AAAA, 32'h12345678, 0);
    vecs[10] = mk(2'b10, 3, 3, 32'h0BADF00D, 32'hCAFEF00D, 4'b1111, 3, 3, 9, 3,
                  32'hCAFEF00D, 32'hCAFEF00D, 32'h12345678, 32'hCAFEF00D);
    vecs[11] = mk(2'b00, 0, 0, 0, 0, 4'b1111, 3, 9, 7, 10, 32'hCAFEF00D, 32'h12345678, 32'h22222222, 32'hAAAA5555);

    rstn = 1'b0; clr_req = 1'b0; we = '0; waddr = '0; wdata = '0; re = '0; raddr = '0;
    clear_left = DEPTH;
    mdl_clear();

    // Reset, then the initial sweep with ignored write noise.
    re = 4'hF;
    repeat (3) step(1'b0, '0);
    rstn = 1'b1;
    count_sweep("reset_sweep_len", 1'b1);
    read_all_zero();

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      re = vecs[i].re; raddr = vecs[i].raddr;
      step(1'b1, vecs[i].exp);
    end

    // Random traffic with collisions, r0 hits, bypass hits and rare clears.
    for (int i = 0; i < 400; i++) begin
      we    = 2'($urandom);
      waddr = 10'($urandom);
      if ($urandom_range(0, 3) == 0) waddr[9:5] = waddr[4:0];
      if ($urandom_range(0, 7) == 0) waddr[4:0] = 5'd0;
      wdata = {$urandom, $urandom};
      re    = 4'($urandom);
      raddr = 20'($urandom);
      for (int j = 0; j < NUM_RD; j++) begin
        if ($urandom_range(0, 1) == 1) raddr[j*ADDR_W +: ADDR_W] = waddr[$urandom_range(0, 1)*ADDR_W +: ADDR_W];
      end
      clr_req = ($urandom_range(0, 63) == 0);
      step(1'b0, '0);
    end
    clr_req = 1'b0;
    we = '0;
    n = 0;
    while (!ready && n < 100) begin
      step(1'b0, '0);
      n++;
    end
    check("ready_after_random", 32'(ready), 32'd1);

    // Fill r1..r31, then clear with writes and a second pulse during the sweep.
    for (int i = 0; i < 16; i++) begin
      we    = 2'b11;
      waddr = {5'(2*i+2), 5'(2*i+1)};
      wdata = {32'hA5000000 | 32'(2*i+2), 32'hA5000000 | 32'(2*i+1)};
      step(1'b0, '0);
    end
    we = '0; re = 4'hF; raddr = {5'd31, 5'd17, 5'd2, 5'd1};
    step(1'b1, {32'hA500001F, 32'hA5000011, 32'hA5000002, 32'hA5000001});
    clr_req = 1'b1;
    step(1'b0, '0);
    clr_req = 1'b0;
    check("ready_drop_after_clr", 32'(ready), 32'd0);
    count_sweep("clr_sweep_len", 1'b1);
    read_all_zero();

    // Reset asserted mid-sweep restarts the full sweep.
    clr_req = 1'b1;
    step(1'b0, '0);
    clr_req = 1'b0;
    repeat (10) step(1'b0, '0);
    rstn = 1'b0;
    clear_left = DEPTH;
    mdl_clear();
    #1;
    check("ready_async_rst", 32'(ready), 32'd0);
    repeat (2) step(1'b0, '0);
    rstn = 1'b1;
    count_sweep("rst_mid_sweep_len", 1'b0);
    read_all_zero();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
